// File: rtl/reward_engine_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// reward_engine_pkg: shared field offsets, sentinel, FSM states
// Rev 1.0
// ------------------------------------------------------------------
package reward_engine_pkg;

  localparam logic [1:0] FLD_NODE    = 2'd0;
  localparam logic [1:0] FLD_CLUSTER = 2'd1;
  localparam logic [1:0] FLD_HOP     = 2'd2;
  localparam logic [1:0] FLD_ENERGY  = 2'd3;

  localparam logic [63:0] SENTINEL_ALL = '1;

  localparam int DEF_HOP_WEIGHT    = 8;
  localparam int DEF_CLUSTER_BONUS = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CALC    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reward_engine_calc.sv
`default_nettype none
// ------------------------------------------------------------------
// reward_calc: combinational saturated score energy + bonus - hops*weight
// Rev 1.0
// ------------------------------------------------------------------
module reward_calc
  import reward_engine_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int HOP_WEIGHT    = DEF_HOP_WEIGHT,
  parameter int CLUSTER_BONUS = DEF_CLUSTER_BONUS
) (
  input  logic [WORD_WIDTH-1:0] energy,
  input  logic                  cluster_match,
  input  logic [WORD_WIDTH-1:0] hop_count,
  output logic [WORD_WIDTH-1:0] reward
);

  // Wide enough that no hop_count/weight combination can wrap before clamping.
  localparam int CW = 2 * WORD_WIDTH + 4;
  localparam logic signed [CW-1:0] MAX_S = CW'({WORD_WIDTH{1'b1}});

  logic signed [CW-1:0] energy_s;
  logic signed [CW-1:0] bonus_s;
  logic signed [CW-1:0] penalty_s;
  logic signed [CW-1:0] score_s;

  always_comb begin
    energy_s  = $signed(CW'(energy));
    bonus_s   = cluster_match ? $signed(CW'(CLUSTER_BONUS)) : '0;
    penalty_s = $signed(CW'(hop_count)) * $signed(CW'(HOP_WEIGHT));
    score_s   = energy_s + bonus_s - penalty_s;
    if (score_s[CW-1]) begin
      reward = '0;
    end else if (score_s > MAX_S) begin
      reward = '1;
    end else begin
      reward = score_s[WORD_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/reward_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// reward_engine: neighbour-table scan, per-entry reward, best-hop select
// Rev 1.0
// ------------------------------------------------------------------
module reward_engine
  import reward_engine_pkg::*;
#(
  parameter int          WORD_WIDTH    = 16,
  parameter int          NUM_CAND      = 4,
  parameter int unsigned TBL_BASE      = 'h0100,
  parameter int          ENTRY_WORDS   = 4,
  parameter int          HOP_WEIGHT    = DEF_HOP_WEIGHT,
  parameter int          CLUSTER_BONUS = DEF_CLUSTER_BONUS
) (
  input  logic                             clock,
  input  logic                             nreset,
  input  logic                             done_prev,
  input  logic [WORD_WIDTH-1:0]            my_node_id,
  input  logic [WORD_WIDTH-1:0]            my_cluster_id,
  output logic [WORD_WIDTH-1:0]            address,
  input  logic [WORD_WIDTH-1:0]            mem_data_out,
  output logic [NUM_CAND*WORD_WIDTH-1:0]   reward_data_out,
  output logic [idx_width(NUM_CAND)-1:0]   best_action,
  output logic [WORD_WIDTH-1:0]            besthop,
  output logic                             best_valid,
  output logic                             done_reward
);

  localparam int IW = idx_width(NUM_CAND);
  localparam int RW = NUM_CAND * WORD_WIDTH;
  localparam logic [WORD_WIDTH-1:0] SENTINEL = SENTINEL_ALL[WORD_WIDTH-1:0];

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [1:0]            fld_q, fld_d;
  logic [WORD_WIDTH-1:0] address_q, address_d;
  logic [WORD_WIDTH-1:0] node_q, node_d;
  logic [WORD_WIDTH-1:0] cluster_q, cluster_d;
  logic [WORD_WIDTH-1:0] hop_q, hop_d;
  logic [WORD_WIDTH-1:0] energy_q, energy_d;
  logic [RW-1:0]         reward_q, reward_d;
  logic [IW-1:0]         best_action_q, best_action_d;
  logic [WORD_WIDTH-1:0] besthop_q, besthop_d;
  logic [WORD_WIDTH-1:0] best_reward_q, best_reward_d;
  logic                  best_valid_q, best_valid_d;
  logic                  done_reward_q, done_reward_d;
  logic                  done_prev_q, done_prev_d;
  logic                  start_q, start_d;

  logic                  cluster_match;
  logic [WORD_WIDTH-1:0] calc_reward;
  logic                  last_entry;

  assign cluster_match = (cluster_q == my_cluster_id);
  assign last_entry    = (int'(idx_q) == NUM_CAND - 1);

  reward_calc #(
    .WORD_WIDTH   (WORD_WIDTH),
    .HOP_WEIGHT   (HOP_WEIGHT),
    .CLUSTER_BONUS(CLUSTER_BONUS)
  ) u_calc (
    .energy       (energy_q),
    .cluster_match(cluster_match),
    .hop_count    (hop_q),
    .reward       (calc_reward)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fld_d         = fld_q;
    address_d     = address_q;
    node_d        = node_q;
    cluster_d     = cluster_q;
    hop_d         = hop_q;
    energy_d      = energy_q;
    reward_d      = reward_q;
    best_action_d = best_action_q;
    besthop_d     = besthop_q;
    best_reward_d = best_reward_q;
    best_valid_d  = best_valid_q;
    done_prev_d   = done_prev;
    start_d       = done_prev & ~done_prev_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d       = ST_ISSUE;
          idx_d         = '0;
          fld_d         = FLD_NODE;
          reward_d      = '0;
          best_action_d = '0;
          besthop_d     = '0;
          best_reward_d = '0;
          best_valid_d  = 1'b0;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        case (fld_q)
          FLD_NODE: begin
            node_d = mem_data_out;
            if (mem_data_out == SENTINEL) begin
              state_d = ST_DONE;
            end else if (mem_data_out == my_node_id) begin
              state_d = ST_NEXT;
            end else begin
              fld_d   = FLD_CLUSTER;
              state_d = ST_ISSUE;
            end
          end
          FLD_CLUSTER: begin
            cluster_d = mem_data_out;
            fld_d     = FLD_HOP;
            state_d   = ST_ISSUE;
          end
          FLD_HOP: begin
            hop_d   = mem_data_out;
            fld_d   = FLD_ENERGY;
            state_d = ST_ISSUE;
          end
          default: begin
            energy_d = mem_data_out;
            state_d  = ST_CALC;
          end
        endcase
      end
      // CALC advances on its own so a full entry costs 9 cycles; NEXT serves the self-skip path.
      ST_CALC: begin
        reward_d[int'(idx_q)*WORD_WIDTH +: WORD_WIDTH] = calc_reward;
        if (!best_valid_q || (calc_reward > best_reward_q)) begin
          best_valid_d  = 1'b1;
          best_action_d = idx_q;
          besthop_d     = node_q;
          best_reward_d = calc_reward;
        end
        if (last_entry) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          fld_d   = FLD_NODE;
          state_d = ST_ISSUE;
        end
      end
      ST_NEXT: begin
        if (last_entry) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          fld_d   = FLD_NODE;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ISSUE) begin
      address_d = WORD_WIDTH'(TBL_BASE + int'(idx_d) * ENTRY_WORDS + int'(fld_d));
    end else if ((state_d == ST_DONE) || (state_d == ST_IDLE)) begin
      address_d = '0;
    end
    done_reward_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      fld_q         <= FLD_NODE;
      address_q     <= '0;
      node_q        <= '0;
      cluster_q     <= '0;
      hop_q         <= '0;
      energy_q      <= '0;
      reward_q      <= '0;
      best_action_q <= '0;
      besthop_q     <= '0;
      best_reward_q <= '0;
      best_valid_q  <= 1'b0;
      done_reward_q <= 1'b0;
      done_prev_q   <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fld_q         <= fld_d;
      address_q     <= address_d;
      node_q        <= node_d;
      cluster_q     <= cluster_d;
      hop_q         <= hop_d;
      energy_q      <= energy_d;
      reward_q      <= reward_d;
      best_action_q <= best_action_d;
      besthop_q     <= besthop_d;
      best_reward_q <= best_reward_d;
      best_valid_q  <= best_valid_d;
      done_reward_q <= done_reward_d;
      done_prev_q   <= done_prev_d;
      start_q       <= start_d;
    end
  end

  assign address         = address_q;
  assign reward_data_out = reward_q;
  assign best_action     = best_action_q;
  assign besthop         = besthop_q;
  assign best_valid      = best_valid_q;
  assign done_reward     = done_reward_q;

endmodule
`default_nettype wire

// File: tb/tb_reward_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_reward_engine: scoreboard bench with behavioural table-scan model
// Rev 1.0
// ------------------------------------------------------------------
module tb_reward_engine;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int TBL = 'h0100;
  localparam int MAX_LAT = 9 * N + 2;

  typedef struct packed {
    logic [N*W-1:0] rewards;
    logic [1:0]     act;
    logic [W-1:0]   hop;
    logic           bv;
  } exp_t;

  logic           clock = 1'b0;
  logic           nreset = 1'b0;
  logic           done_prev = 1'b0;
  logic [W-1:0]   my_node_id = '0;
  logic [W-1:0]   my_cluster_id = '0;
  logic [W-1:0]   address;
  logic [W-1:0]   mem_data_out = '0;
  logic [N*W-1:0] reward_data_out;
  logic [1:0]     best_action;
  logic [W-1:0]   besthop;
  logic           best_valid;
  logic           done_reward;

  logic [W-1:0] mem [0:65535];
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  logic prev_done = 1'b0;

  reward_engine dut (
    .clock          (clock),
    .nreset         (nreset),
    .done_prev      (done_prev),
    .my_node_id     (my_node_id),
    .my_cluster_id  (my_cluster_id),
    .address        (address),
    .mem_data_out   (mem_data_out),
    .reward_data_out(reward_data_out),
    .best_action    (best_action),
    .besthop        (besthop),
    .best_valid     (best_valid),
    .done_reward    (done_reward)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_data_out <= mem[address];
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan semantics straight from the table rules: sentinel ends the scan,
  // own ID is skipped, score is clamped, strict '>' keeps the lowest index on ties.
  function automatic exp_t model(input logic [W-1:0] mn, input logic [W-1:0] mc);
    exp_t   e;
    longint r, br;
    int     b;
    e  = '0;
    br = 0;
    for (int i = 0; i < N; i++) begin
      b = TBL + 4 * i;
      if (mem[b] == 16'hFFFF) break;
      if (mem[b] == mn) continue;
      r = longint'(mem[b+3]) + ((mem[b+1] == mc) ? 64 : 0) - longint'(mem[b+2]) * 8;
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
      e.rewards[i*W +: W] = r[W-1:0];
      if (!e.bv || r > br) begin
        e.bv  = 1'b1;
        e.act = 2'(i);
        e.hop = mem[b];
        br    = r;
      end
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (nreset && done_reward) begin
      done_count++;
      last_done_cyc = cyc;
      if (prev_done) check("done_pulse_width", 64'd2, 64'd1);
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        check("rewards", 64'(reward_data_out), 64'(mon_e.rewards));
        check("best_action", 64'(best_action), 64'(mon_e.act));
        check("besthop", 64'(besthop), 64'(mon_e.hop));
        check("best_valid", 64'(best_valid), 64'(mon_e.bv));
      end
    end
    prev_done = nreset && done_reward;
  end

  task automatic load_entry(input int i, input logic [W-1:0] n, input logic [W-1:0] c,
                            input logic [W-1:0] h, input logic [W-1:0] e);
    mem[TBL+4*i]   = n;
    mem[TBL+4*i+1] = c;
    mem[TBL+4*i+2] = h;
    mem[TBL+4*i+3] = e;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) load_entry(i, 16'hFFFF, 0, 0, 0);
  endtask

  task automatic load_basic();
    clear_table();
    load_entry(0, 5, 3, 2, 100);
    load_entry(1, 6, 3, 1, 90);
    load_entry(2, 7, 4, 1, 120);
  endtask

  task automatic wait_done(input int c0, input int budget);
    int n;
    n = 0;
    while (done_count == c0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("done_timeout", 64'(done_count != c0), 64'd1);
  endtask

  task automatic do_run(input logic [W-1:0] mn, input logic [W-1:0] mc, input int max_lat);
    int c0, t0;
    my_node_id    = mn;
    my_cluster_id = mc;
    q.push_back(model(mn, mc));
    @(negedge clock);
    c0 = done_count;
    t0 = cyc;
    done_prev = 1'b1;
    repeat (2) @(negedge clock);
    done_prev = 1'b0;
    wait_done(c0, 100);
    check("latency", 64'((last_done_cyc - t0) <= max_lat), 64'd1);
    @(negedge clock);
    check("address_idle", 64'(address), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_rewards"}, 64'(reward_data_out), 64'd0);
    check({tag, "_best_action"}, 64'(best_action), 64'd0);
    check({tag, "_besthop"}, 64'(besthop), 64'd0);
    check({tag, "_best_valid"}, 64'(best_valid), 64'd0);
    check({tag, "_done_reward"}, 64'(done_reward), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, sel;
    logic [W-1:0] mn, mc, nid, hop;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    clear_table();

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    // Basic scan
    load_basic();
    do_run(2, 3, MAX_LAT);

    // Saturation low (eligible at zero) and high
    clear_table();
    load_entry(0, 9, 4, 10, 2);
    do_run(2, 3, MAX_LAT);
    clear_table();
    load_entry(0, 9, 3, 0, 16'hFFF0);
    do_run(2, 3, MAX_LAT);

    // Tie and self-skip
    clear_table();
    load_entry(0, 2, 3, 0, 500);
    load_entry(1, 8, 3, 1, 100);
    load_entry(2, 4, 3, 1, 100);
    load_entry(3, 11, 4, 0, 0);
    do_run(2, 3, MAX_LAT);

    // Empty table
    clear_table();
    do_run(2, 3, 4);

    // done_prev held high for 400 time units: exactly one run
    load_basic();
    q.push_back(model(2, 3));
    @(negedge clock);
    c0 = done_count;
    done_prev = 1'b1;
    repeat (40) @(negedge clock);
    done_prev = 1'b0;
    wait_done(c0, 100);
    repeat (50) @(negedge clock);
    check("held_high_runs", 64'(done_count), 64'(c0 + 1));

    // Second edge mid-run is ignored
    q.push_back(model(2, 3));
    c0 = done_count;
    done_prev = 1'b1;
    repeat (2) @(negedge clock);
    done_prev = 1'b0;
    repeat (10) @(negedge clock);
    done_prev = 1'b1;
    repeat (2) @(negedge clock);
    done_prev = 1'b0;
    wait_done(c0, 100);
    repeat (50) @(negedge clock);
    check("mid_edge_runs", 64'(done_count), 64'(c0 + 1));

    // Re-toggle after completion gives an identical second result
    do_run(2, 3, MAX_LAT);

    // Reset during entry 2 aborts the run
    load_basic();
    c0 = done_count;
    done_prev = 1'b1;
    repeat (2) @(negedge clock);
    done_prev = 1'b0;
    n = 0;
    while (address != 16'(TBL + 8) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("reach_entry2", 64'(address), 64'(TBL + 8));
    nreset = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    nreset = 1'b1;
    repeat (60) @(negedge clock);
    check("no_done_after_reset", 64'(done_count), 64'(c0));
    do_run(2, 3, MAX_LAT);

    // Randomised tables
    for (int t = 0; t < 24; t++) begin
      mn = 16'($urandom_range(1, 20));
      mc = 16'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) nid = 16'hFFFF;
        else if (sel <= 2) nid = mn;
        else nid = 16'($urandom_range(1, 30));
        hop = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 20));
        load_entry(i, nid, 16'($urandom_range(0, 3)), hop, 16'($urandom_range(0, 65535)));
      end
      do_run(mn, mc, MAX_LAT);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
